// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - byte stream handshake between the register dumper and its sink
interface regfile_dump_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - streams registers FIRST_REG..LAST_REG out as little-endian bytes
module regfile_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic [4:0]    Read1,
  input  logic [31:0]   Data1,
  output logic          busy,
  output logic          done,
  regfile_dump_if.master out
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  read_q, read_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      read_q  <= 5'd0;
      shift_q <= 32'd0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // In SEND out_valid is always high, so out_ready alone marks a transfer.
  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          read_d  = FIRST_IDX;
          state_d = READ;
        end
      end
      READ: begin
        shift_d = Data1;
        cnt_d   = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        if (out.out_ready) begin
          if (cnt_q != 2'd3) begin
            shift_d = shift_q >> 8;
            cnt_d   = cnt_q + 2'd1;
          end else if (read_q < LAST_IDX) begin
            read_d  = read_q + 5'd1;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Read1         = read_q;
    out.out_data  = shift_q[7:0];
    out.out_valid = (state_q == SEND);
    busy          = (state_q == READ) || (state_q == SEND);
    done          = (state_q == DONE);
  end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter FIRST_REG, default 0: first register index dumped (0..31).
REQ-002 Parameter LAST_REG, default 31: last register index dumped (FIRST_REG..31).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports named clock and reset as elsewhere in the codebase.
REQ-004 clock  input  1  rising-edge clock shared with registerfile.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-007 Read1  output  5  register index driven to the registerfile read port 1.
REQ-008 Data1  input  32  combinational read data from registerfile for index Read1.
REQ-009 out_data  output  8  current byte of the dump stream.
REQ-010 out_valid  output  1  out_data holds a valid byte.
REQ-011 out_ready  input  1  downstream accepts the byte when high with out_valid.
REQ-012 busy  output  1  high while a dump is in progress (READ or SEND).
REQ-013 done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, READ, SEND, DONE.
REQ-015 IDLE: start=1 SHALL load Read1<=FIRST_REG and go to READ next cycle; start=0 stays in IDLE.
REQ-016 READ (exactly one cycle): the block SHALL capture Data1 into a 32-bit shift register, clear a 2-bit byte counter, go to SEND.
REQ-017 SEND: out_valid SHALL be 1 and out_data SHALL equal shift register bits [7:0].
REQ-018 A byte is transferred on a rising edge where out_valid and out_ready are both 1; nothing else advances SEND.
REQ-019 While out_valid=1 and out_ready=0, out_data, Read1 and the byte counter SHALL hold unchanged.
REQ-020 On a transfer with byte counter<3: shift register shifts right 8 bits, counter increments, stay in SEND.
REQ-021 On a transfer with byte counter=3 and Read1<LAST_REG: Read1 increments by 1, go to READ.
REQ-022 On a transfer with byte counter=3 and Read1=LAST_REG: go to DONE.
REQ-023 Byte order SHALL be little-endian per register (bits [7:0] first), registers in ascending index order.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE; Read1 holds LAST_REG.
REQ-025 start SHALL be ignored in READ, SEND and DONE; no restart, no queuing.
REQ-026 busy SHALL be 1 exactly in READ and SEND; out_valid SHALL be 0 in IDLE, READ, DONE.
REQ-027 Latency with out_ready held 1: first byte valid 2 cycles after start sampled; done asserted (LAST_REG-FIRST_REG+1)*5+1 cycles after start sampled.
REQ-028 Total bytes per dump SHALL be 4*(LAST_REG-FIRST_REG+1); no bytes dropped or duplicated under any out_ready pattern.
REQ-029 The block SHALL never write the register file; it is read-only on Read1/Data1.

Reset
REQ-030 On reset=1 at a rising edge: state IDLE, Read1=0, shift register=0, byte counter=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-031 reset SHALL take priority over start and over any in-flight transfer; a reset mid-dump aborts it with no done pulse.

Verification
REQ-032 Default params, regs x3=0xABCDEFFF, x5=0xFBCDE111, others 0, out_ready=1, pulse start -> 128 bytes; bytes 12..15 = FF EF CD AB; bytes 20..23 = 11 E1 CD FB; bytes 0..3 = 00; done exactly 161 cycles after start sampled.
REQ-033 Same setup, out_ready=0 for 3 cycles while byte 21 (0xE1) presented -> out_data stays 0xE1, Read1 stays 5, stream resumes with 0xCD, done delayed by exactly 3 cycles.
REQ-034 Pulse start again at cycle 50 of a dump -> byte count stays 128, single done pulse, Read1 sequence unchanged.
REQ-035 Assert reset during SEND of register 10 -> next cycle out_valid=0, busy=0, Read1=0; later start yields full 128-byte dump from x0.
REQ-036 FIRST_REG=3, LAST_REG=5 -> 12 bytes: FF EF CD AB 00 00 00 00 11 E1 CD FB; done 16 cycles after start.
REQ-037 out_ready toggling randomly each cycle for a full dump -> received byte stream identical to REQ-032 stream.
